// File: rtl/pqr5_core_pkg.sv
// Core-wide constants shared by every pqr5 block.
package pqr5_core_pkg;
  localparam int DSIZE = 32;
endpackage

// File: rtl/pqr5_subsystem_pkg.sv
// Subsystem-level types for the pqr5 host-to-memory loader.
package pqr5_subsystem_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/pqr5_byte_packer.sv
// Little-endian byte-to-word packer: lanes 0..2 are held, lane 3 passes
// straight through so the full word is available on the 4th byte's cycle.
module pqr5_byte_packer
  import pqr5_core_pkg::*;
(
  input  logic             clk,
  input  logic             aresetn,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_i,
  input  logic [1:0]       idx_i,
  output logic [DSIZE-1:0] word_o,
  output logic             word_valid_o
);

  logic [23:0] low_bytes;

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [7:0] lane_q;
    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        lane_q <= '0;
      end else if (byte_valid_i && (idx_i == 2'(gi))) begin
        lane_q <= byte_i;
      end
    end
    assign low_bytes[gi*8 +: 8] = lane_q;
  end

  assign word_o       = DSIZE'({byte_i, low_bytes});
  assign word_valid_o = byte_valid_i && (idx_i == 2'd3);

endmodule

// File: rtl/pqr5_mem_loader.sv
// Loads a length-prefixed little-endian byte stream into word memory,
// issuing one registered write strobe per assembled word.
module pqr5_mem_loader
  import pqr5_core_pkg::*;
  import pqr5_subsystem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int ASIZE = 32
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             start_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic             rx_ready_o,
  output logic             mem_wr_o,
  output logic [ASIZE-1:0] mem_addr_o,
  output logic [DSIZE-1:0] mem_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      wcnt_o
);

  loader_state_e    state_q;
  logic             rx_ready_q;
  logic             mem_wr_q;
  logic [ASIZE-1:0] mem_addr_q;
  logic [DSIZE-1:0] mem_data_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [31:0]      wcnt_q;
  logic [31:0]      wcnt_d;
  logic [31:0]      n_q;
  logic [1:0]       bidx_q;

  logic             byte_acc;
  logic [DSIZE-1:0] word;
  logic             word_valid;

  assign byte_acc = rx_valid_i && rx_ready_q;
  assign wcnt_d   = wcnt_q + 32'd1;

  pqr5_byte_packer u_packer (
    .clk          (clk),
    .aresetn      (aresetn),
    .byte_valid_i (byte_acc),
    .byte_i       (rx_data_i),
    .idx_i        (bidx_q),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      rx_ready_q <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wcnt_q     <= '0;
      n_q        <= '0;
      bidx_q     <= '0;
    end else begin
      mem_wr_q <= 1'b0;
      if (byte_acc) begin
        bidx_q <= bidx_q + 2'd1;
      end
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            state_q    <= ST_LEN;
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wcnt_q     <= '0;
            n_q        <= '0;
            bidx_q     <= '0;
          end
        end
        ST_LEN: begin
          if (word_valid) begin
            n_q <= word;
            if (word == '0) begin
              state_q    <= ST_DONE;
              rx_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else if (word > 32'(DEPTH)) begin
              state_q    <= ST_ERR;
              rx_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          // Counter, strobe and completion all move on the same edge so the
          // write cycle already shows the final count and DONE status.
          if (word_valid) begin
            mem_wr_q   <= 1'b1;
            mem_addr_q <= ASIZE'({wcnt_q[29:0], 2'b00});
            mem_data_q <= word;
            wcnt_q     <= wcnt_d;
            if (wcnt_d == n_q) begin
              state_q    <= ST_DONE;
              rx_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          rx_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready_o = rx_ready_q;
  assign mem_wr_o   = mem_wr_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign wcnt_o     = wcnt_q;

endmodule

// File: tb/tb_pqr5_mem_loader.sv
// Randomised bench for pqr5_mem_loader against a transaction-level model.
module tb_pqr5_mem_loader;
  localparam int DEPTH = 1024;
  localparam int ASIZE = 32;

  localparam int P_IDLE = 0;
  localparam int P_LEN  = 1;
  localparam int P_DATA = 2;
  localparam int P_DONE = 3;
  localparam int P_ERR  = 4;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic        mem_wr_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] wcnt_o;

  always #5 clk = ~clk;

  pqr5_mem_loader #(.DEPTH(DEPTH), .ASIZE(ASIZE)) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .start_i    (start_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .mem_wr_o   (mem_wr_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .wcnt_o     (wcnt_o)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t        obs[$];
  logic [7:0] tx_q[$];
  logic [31:0] words[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: loader behaviour expressed as phase + byte counter + word counter.
  int          m_phase = P_IDLE;
  int          m_bidx = 0;
  logic [31:0] m_word = 0;
  logic [31:0] m_n = 0;
  logic [31:0] m_wcnt = 0;
  logic        m_wr = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] m_data = 0;

  always @(posedge clk) begin
    if (!aresetn) begin
      m_phase = P_IDLE; m_bidx = 0; m_word = 0; m_n = 0;
      m_wcnt = 0; m_wr = 0; m_addr = 0; m_data = 0;
    end else begin
      m_wr = 0;
      if ((m_phase == P_IDLE || m_phase == P_DONE || m_phase == P_ERR) && start_i) begin
        m_phase = P_LEN; m_bidx = 0; m_wcnt = 0; m_n = 0;
      end else if ((m_phase == P_LEN || m_phase == P_DATA) && rx_valid_i) begin
        m_word[m_bidx*8 +: 8] = rx_data_i;
        if (m_bidx == 3) begin
          if (m_phase == P_LEN) begin
            m_n = m_word;
            if (m_n == 0) m_phase = P_DONE;
            else if (m_n > DEPTH) m_phase = P_ERR;
            else m_phase = P_DATA;
          end else begin
            m_wr = 1; m_addr = m_wcnt * 4; m_data = m_word;
            m_wcnt = m_wcnt + 1;
            if (m_wcnt == m_n) m_phase = P_DONE;
          end
        end
        m_bidx = (m_bidx + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin
    if (!aresetn) begin
      chk("rst_rx_ready", rx_ready_o, 0);
      chk("rst_mem_wr", mem_wr_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_data", mem_data_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_wcnt", wcnt_o, 0);
    end else begin
      chk("rx_ready", rx_ready_o, (m_phase == P_LEN || m_phase == P_DATA));
      chk("busy", busy_o, (m_phase == P_LEN || m_phase == P_DATA));
      chk("done", done_o, (m_phase == P_DONE));
      chk("err", err_o, (m_phase == P_ERR));
      chk("wcnt", wcnt_o, m_wcnt);
      chk("mem_wr", mem_wr_o, m_wr);
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_data", mem_data_o, m_data);
    end
    if (aresetn && mem_wr_o) begin
      obs.push_back({mem_addr_o, mem_data_o});
      $display("write addr=%h data=%h wcnt=%0d", mem_addr_o, mem_data_o, wcnt_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) tx_q.push_back(w[k*8 +: 8]);
  endtask

  task automatic send_bytes(input bit toggle, input bit poke_start);
    int i = 0;
    while (i < tx_q.size()) begin
      if (!toggle || ($urandom_range(1, 0) == 1)) begin
        rx_valid_i = 1'b1;
        rx_data_i  = tx_q[i];
        i++;
      end else begin
        rx_valid_i = 1'b0;
        rx_data_i  = 8'($urandom);
      end
      start_i = poke_start && ($urandom_range(3, 0) == 0);
      tick();
    end
    rx_valid_i = 1'b0;
    start_i    = 1'b0;
    tx_q.delete();
  endtask

  task automatic wait_end(input int max_cycles);
    int c = 0;
    while (!(done_o || err_o) && c < max_cycles) begin
      tick();
      c++;
    end
    chk("end_reached", (done_o || err_o), 1);
    tick();
  endtask

  task automatic random_load(input int n, input bit toggle, input bit poke);
    obs.delete();
    words.delete();
    pulse_start();
    push_word(32'(n));
    for (int k = 0; k < n; k++) begin
      words.push_back($urandom);
      push_word(words[k]);
    end
    send_bytes(toggle, poke);
    wait_end(100);
    chk("load_writes", obs.size(), n);
    for (int k = 0; k < n && k < obs.size(); k++) begin
      chk("load_addr", obs[k].a, 32'(k * 4));
      chk("load_data", obs[k].d, words[k]);
    end
    chk("load_wcnt", wcnt_o, n);
    chk("load_done", done_o, 1);
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_wcnt_lit", wcnt_o, 0);
    chk("reset_ready_lit", rx_ready_o, 0);
    aresetn = 1'b1;
    tick();
    chk("idle_ready_lit", rx_ready_o, 0);

    // Two-word load with fixed data.
    obs.delete();
    pulse_start();
    tx_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_bytes(0, 0);
    wait_end(20);
    chk("t1_nwrites", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("t1_addr0", obs[0].a, 32'h0);
      chk("t1_data0", obs[0].d, 32'h12345678);
      chk("t1_addr1", obs[1].a, 32'h4);
      chk("t1_data1", obs[1].d, 32'hDEADBEEF);
    end
    chk("t1_done", done_o, 1);
    chk("t1_wcnt", wcnt_o, 2);
    chk("t1_busy", busy_o, 0);

    // Zero-length load.
    obs.delete();
    pulse_start();
    tx_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(0, 0);
    tick();
    chk("t2_done", done_o, 1);
    chk("t2_wcnt", wcnt_o, 0);
    chk("t2_nwrites", obs.size(), 0);

    // Over-length load, trailing bytes must be ignored.
    obs.delete();
    pulse_start();
    tx_q = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_bytes(0, 0);
    tick();
    chk("t3_err", err_o, 1);
    chk("t3_done", done_o, 0);
    chk("t3_ready", rx_ready_o, 0);
    chk("t3_nwrites", obs.size(), 0);

    // Three words, toggling valid and stray start pulses.
    random_load(3, 1, 1);

    // Reset in the middle of the first word.
    obs.delete();
    pulse_start();
    tx_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    send_bytes(0, 0);
    aresetn = 1'b0;
    tick();
    tick();
    chk("t5_rst_wcnt", wcnt_o, 0);
    chk("t5_rst_busy", busy_o, 0);
    aresetn = 1'b1;
    tick();
    chk("t5_nwrites_abort", obs.size(), 0);
    pulse_start();
    tx_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    send_bytes(0, 0);
    wait_end(20);
    chk("t5_nwrites", obs.size(), 1);
    if (obs.size() == 1) begin
      chk("t5_addr", obs[0].a, 32'h0);
      chk("t5_data", obs[0].d, 32'h11223344);
    end

    for (int r = 0; r < 6; r++) begin
      random_load($urandom_range(8, 1), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    // Full-depth load, exact boundary is legal.
    random_load(DEPTH, 0, 0);
    if (obs.size() == DEPTH) chk("t7_last_addr", obs[DEPTH-1].a, 32'((DEPTH - 1) * 4));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
